// File: rtl/opamp_stim_dac.sv
// ---------------------------------------------------------------------------
// opamp_stim_dac
//
// Digital stimulus generator for the opamp's non-inverting input. A
// first-order sigma-delta modulator turns a WIDTH-bit code into a 1-bit
// density stream. An off-chip RC low-pass filter turns that stream into the
// analog level on vin_p. The modulated code is static, a triangle sweep, or
// a square step between 0 and the loaded code.
//
// Ports
//   clk      : system clock, all state updates on its rising edge
//   rst_n    : synchronous active-low reset, has priority over ena
//   ena      : block enable; low clears the modulator and prescaler and
//              holds the waveform state
//   code_in  : code to load (WIDTH bits)
//   load     : level-sensitive load strobe for code_in (needs ena=1)
//   mode     : 0 static, 1 triangle, 2 square, 3 reserved (acts as static)
//   dac_out  : sigma-delta bitstream to the RC filter
//   cur_code : code currently being modulated
//   dir_up   : triangle direction, 1 while ramping up
//   tick     : one-cycle pulse on each waveform update
//
// Parameters
//   WIDTH : code width in bits
//   DIV   : clocks per waveform update tick, legal range 2..65536
// ---------------------------------------------------------------------------
module opamp_stim_dac #(
    parameter int WIDTH = 8,
    parameter int DIV   = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] code_in,
    input  logic             load,
    input  logic [1:0]       mode,
    output logic             dac_out,
    output logic [WIDTH-1:0] cur_code,
    output logic             dir_up,
    output logic             tick
);

    localparam int              PW         = $clog2(DIV);
    localparam logic [PW-1:0]   PRESC_MAX  = PW'(DIV - 1);
    localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] CODE_MAX  = '1;
    localparam logic [WIDTH-1:0] CODE_ONE  = WIDTH'(1);
    localparam logic [1:0]      MODE_TRI   = 2'd1;
    localparam logic [1:0]      MODE_SQ    = 2'd2;

    // State registers
    logic [WIDTH-1:0] code_q,     code_d;
    logic [WIDTH-1:0] acc_q,      acc_d;
    logic [PW-1:0]    presc_q,    presc_d;
    logic             sq_phase_q, sq_phase_d;
    logic [1:0]       mode_q,     mode_d;
    logic [WIDTH-1:0] cur_code_q, cur_code_d;
    logic             dir_up_q,   dir_up_d;
    logic             tick_q,     tick_d;
    logic             dac_q,      dac_d;

    // Modulator sum. Only the low WIDTH bits of the accumulator are carried
    // forward; the top bit is the carry that becomes the output pulse, so it
    // lives in dac_q rather than in acc_q.
    logic [WIDTH:0] acc_sum;
    logic           mode_chg;
    logic           step_now;

    always_comb begin
        code_d     = code_q;
        acc_d      = acc_q;
        presc_d    = presc_q;
        sq_phase_d = sq_phase_q;
        mode_d     = mode_q;
        cur_code_d = cur_code_q;
        dir_up_d   = dir_up_q;
        tick_d     = 1'b0;
        dac_d      = dac_q;

        acc_sum  = {1'b0, acc_q} + {1'b0, cur_code_q};
        mode_chg = (mode != mode_q);
        step_now = (presc_q == PRESC_MAX);

        if (!ena) begin
            // Disabled: silence the output and restart the modulator and
            // prescaler from zero; waveform state is held for resumption.
            acc_d   = '0;
            dac_d   = 1'b0;
            presc_d = '0;
        end else begin
            acc_d  = acc_sum[WIDTH-1:0];
            dac_d  = acc_sum[WIDTH];
            mode_d = mode;
            if (load) begin
                code_d = code_in;
            end

            if (mode_chg) begin
                // A mode change restarts the waveform timing and suppresses
                // any step that would have happened on this edge.
                presc_d    = '0;
                dir_up_d   = 1'b1;
                sq_phase_d = 1'b0;
            end else begin
                presc_d = step_now ? '0 : presc_q + PRESC_ONE;
                tick_d  = step_now;
                case (mode_q)
                    MODE_TRI: begin
                        if (step_now) begin
                            // Bounce at the endpoints without repeating them.
                            if (dir_up_q) begin
                                if (cur_code_q == CODE_MAX) begin
                                    cur_code_d = CODE_MAX - CODE_ONE;
                                    dir_up_d   = 1'b0;
                                end else begin
                                    cur_code_d = cur_code_q + CODE_ONE;
                                end
                            end else begin
                                if (cur_code_q == '0) begin
                                    cur_code_d = CODE_ONE;
                                    dir_up_d   = 1'b1;
                                end else begin
                                    cur_code_d = cur_code_q - CODE_ONE;
                                end
                            end
                        end
                    end
                    MODE_SQ: begin
                        if (step_now) begin
                            // Uses code_q, so a load on this same edge only
                            // shows up at the next high phase.
                            sq_phase_d = ~sq_phase_q;
                            cur_code_d = (~sq_phase_q) ? code_q : '0;
                        end
                    end
                    default: begin
                        cur_code_d = code_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q     <= '0;
            acc_q      <= '0;
            presc_q    <= '0;
            sq_phase_q <= 1'b0;
            mode_q     <= 2'd0;
            cur_code_q <= '0;
            dir_up_q   <= 1'b1;
            tick_q     <= 1'b0;
            dac_q      <= 1'b0;
        end else begin
            code_q     <= code_d;
            acc_q      <= acc_d;
            presc_q    <= presc_d;
            sq_phase_q <= sq_phase_d;
            mode_q     <= mode_d;
            cur_code_q <= cur_code_d;
            dir_up_q   <= dir_up_d;
            tick_q     <= tick_d;
            dac_q      <= dac_d;
        end
    end

    assign dac_out  = dac_q;
    assign cur_code = cur_code_q;
    assign dir_up   = dir_up_q;
    assign tick     = tick_q;

endmodule

// File: tb/tb_opamp_stim_dac.sv
// ---------------------------------------------------------------------------
// tb_opamp_stim_dac
//
// Directed self-checking bench for opamp_stim_dac with DIV=4. Inputs are
// driven 1 time unit after each rising edge; outputs are sampled at the
// same point, i.e. they show the state produced by the edge just taken.
// ---------------------------------------------------------------------------
module tb_opamp_stim_dac;

    localparam int WIDTH = 8;
    localparam int DIV   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic [WIDTH-1:0] code_in;
    logic             load;
    logic [1:0]       mode;
    logic             dac_out;
    logic [WIDTH-1:0] cur_code;
    logic             dir_up;
    logic             tick;

    int tests_run    = 0;
    int tests_failed = 0;

    // Triangle reference state carried between scenarios.
    int tri_code = 0;
    int tri_dir  = 1;

    always #5 clk = ~clk;

    opamp_stim_dac #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .code_in  (code_in),
        .load     (load),
        .mode     (mode),
        .dac_out  (dac_out),
        .cur_code (cur_code),
        .dir_up   (dir_up),
        .tick     (tick)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance the triangle reference by one tick.
    task automatic tri_model_tick();
        if (tri_dir == 1) begin
            if (tri_code == 255) begin tri_code = 254; tri_dir = 0; end
            else tri_code = tri_code + 1;
        end else begin
            if (tri_code == 0) begin tri_code = 1; tri_dir = 1; end
            else tri_code = tri_code - 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b0; load = 1'b0; code_in = '0; mode = 2'd0;
        step(); step();
        tests_run++; if (cur_code !== 8'd0) begin tests_failed++; $display("FAIL reset_cur_code: got %0d want 0", cur_code); end
        tests_run++; if (dir_up !== 1'b1) begin tests_failed++; $display("FAIL reset_dir_up: got %b want 1", dir_up); end
        tests_run++; if (dac_out !== 1'b0) begin tests_failed++; $display("FAIL reset_dac_out: got %b want 0", dac_out); end
        tests_run++; if (tick !== 1'b0) begin tests_failed++; $display("FAIL reset_tick: got %b want 0", tick); end
        // Reset must beat ena and load.
        ena = 1'b1; load = 1'b1; code_in = 8'd99;
        step(); step();
        tests_run++; if (cur_code !== 8'd0) begin tests_failed++; $display("FAIL reset_priority_cur_code: got %0d want 0", cur_code); end
        tests_run++; if (tick !== 1'b0) begin tests_failed++; $display("FAIL reset_priority_tick: got %b want 0", tick); end
        load = 1'b0;
    endtask

    task automatic test_static_64();
        int ones;
        int bad;
        rst_n = 1'b1; ena = 1'b1; mode = 2'd0; code_in = 8'd64; load = 1'b1;
        step();
        load = 1'b0;
        tests_run++; if (cur_code !== 8'd0) begin tests_failed++; $display("FAIL static_first_edge: got %0d want 0", cur_code); end
        step();
        tests_run++; if (cur_code !== 8'd64) begin tests_failed++; $display("FAIL static_load_latency: got %0d want 64", cur_code); end
        ones = 0; bad = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (dac_out === 1'b1) ones++;
            if (dac_out !== ((i % 4) == 3)) bad++;
        end
        tests_run++; if (ones != 64) begin tests_failed++; $display("FAIL static64_density: got %0d ones want 64", ones); end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL static64_pattern: got %0d off-pattern cycles want 0", bad); end
    endtask

    task automatic test_static_extremes();
        int ones;
        code_in = 8'd0; load = 1'b1;
        step();
        load = 1'b0;
        step();
        tests_run++; if (cur_code !== 8'd0) begin tests_failed++; $display("FAIL static0_code: got %0d want 0", cur_code); end
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (dac_out !== 1'b0) ones++;
        end
        tests_run++; if (ones != 0) begin tests_failed++; $display("FAIL static0_density: got %0d ones want 0", ones); end

        code_in = 8'd255; load = 1'b1;
        step();
        load = 1'b0;
        step();
        tests_run++; if (cur_code !== 8'd255) begin tests_failed++; $display("FAIL static255_code: got %0d want 255", cur_code); end
        ones = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (dac_out === 1'b1) ones++;
        end
        tests_run++; if (ones != 255) begin tests_failed++; $display("FAIL static255_density: got %0d ones want 255", ones); end
    endtask

    task automatic test_triangle();
        int prev;
        code_in = 8'd0; load = 1'b1;
        step();
        load = 1'b0;
        step();
        mode = 2'd1;
        step();
        tests_run++; if (cur_code !== 8'd0) begin tests_failed++; $display("FAIL tri_mode_change_code: got %0d want 0", cur_code); end
        tests_run++; if (tick !== 1'b0) begin tests_failed++; $display("FAIL tri_mode_change_tick: got %b want 0", tick); end
        tri_code = 0; tri_dir = 1;
        // Full sweep 0 -> 255 -> 0 -> 1 is 511 ticks.
        for (int t = 0; t < 511; t++) begin
            prev = tri_code;
            tri_model_tick();
            for (int c = 0; c < 3; c++) begin
                step();
                tests_run++; if (tick !== 1'b0) begin tests_failed++; $display("FAIL tri_tick_idle: t=%0d got %b want 0", t, tick); end
                tests_run++; if (cur_code !== 8'(prev)) begin tests_failed++; $display("FAIL tri_hold: t=%0d got %0d want %0d", t, cur_code, prev); end
            end
            step();
            tests_run++; if (tick !== 1'b1) begin tests_failed++; $display("FAIL tri_tick_pulse: t=%0d got %b want 1", t, tick); end
            tests_run++; if (cur_code !== 8'(tri_code)) begin tests_failed++; $display("FAIL tri_step: t=%0d got %0d want %0d", t, cur_code, tri_code); end
            tests_run++; if (dir_up !== 1'(tri_dir)) begin tests_failed++; $display("FAIL tri_dir: t=%0d got %b want %0d", t, dir_up, tri_dir); end
        end
        tests_run++; if (cur_code !== 8'd1 || dir_up !== 1'b1) begin tests_failed++; $display("FAIL tri_bottom_bounce: got %0d/%b want 1/1", cur_code, dir_up); end
    endtask

    task automatic test_ena_drop();
        for (int t = 0; t < 99; t++) begin
            tri_model_tick();
            for (int c = 0; c < 4; c++) step();
        end
        tests_run++; if (cur_code !== 8'd100) begin tests_failed++; $display("FAIL ena_pre_code: got %0d want 100", cur_code); end
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            tests_run++; if (dac_out !== 1'b0) begin tests_failed++; $display("FAIL ena_off_dac: i=%0d got %b want 0", i, dac_out); end
            tests_run++; if (tick !== 1'b0) begin tests_failed++; $display("FAIL ena_off_tick: i=%0d got %b want 0", i, tick); end
            tests_run++; if (cur_code !== 8'd100) begin tests_failed++; $display("FAIL ena_off_code: i=%0d got %0d want 100", i, cur_code); end
            tests_run++; if (dir_up !== 1'b1) begin tests_failed++; $display("FAIL ena_off_dir: i=%0d got %b want 1", i, dir_up); end
        end
        ena = 1'b1;
        step(); step(); step();
        tests_run++; if (cur_code !== 8'd100) begin tests_failed++; $display("FAIL ena_resume_hold: got %0d want 100", cur_code); end
        step();
        tests_run++; if (cur_code !== 8'd101 || tick !== 1'b1) begin tests_failed++; $display("FAIL ena_resume_101: got %0d/%b want 101/1", cur_code, tick); end
        for (int c = 0; c < 4; c++) step();
        tests_run++; if (cur_code !== 8'd102) begin tests_failed++; $display("FAIL ena_resume_102: got %0d want 102", cur_code); end
        tri_code = 102; tri_dir = 1;
    endtask

    task automatic test_reset_mid_ramp();
        // 102 up to 255 (153 ticks), bounce to 254, down to 180 (74 ticks).
        for (int t = 0; t < 228; t++) begin
            tri_model_tick();
            for (int c = 0; c < 4; c++) step();
        end
        tests_run++; if (cur_code !== 8'd180 || dir_up !== 1'b0) begin tests_failed++; $display("FAIL rst_pre_state: got %0d/%b want 180/0", cur_code, dir_up); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        tests_run++; if (cur_code !== 8'd0) begin tests_failed++; $display("FAIL rst_mid_code: got %0d want 0", cur_code); end
        tests_run++; if (dir_up !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_dir: got %b want 1", dir_up); end
        tests_run++; if (dac_out !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_dac: got %b want 0", dac_out); end
        // First edge after release sees mode 1 against mode_q 0: restart.
        step();
        tests_run++; if (cur_code !== 8'd0 || tick !== 1'b0) begin tests_failed++; $display("FAIL rst_release_edge: got %0d/%b want 0/0", cur_code, tick); end
        step(); step(); step();
        tests_run++; if (cur_code !== 8'd0) begin tests_failed++; $display("FAIL rst_release_hold: got %0d want 0", cur_code); end
        step();
        tests_run++; if (cur_code !== 8'd1 || tick !== 1'b1 || dir_up !== 1'b1) begin tests_failed++; $display("FAIL rst_ramp_1: got %0d/%b/%b want 1/1/1", cur_code, tick, dir_up); end
        for (int c = 0; c < 4; c++) step();
        tests_run++; if (cur_code !== 8'd2) begin tests_failed++; $display("FAIL rst_ramp_2: got %0d want 2", cur_code); end
    endtask

    task automatic test_square();
        code_in = 8'd200; load = 1'b1; mode = 2'd2;
        step();
        load = 1'b0;
        tests_run++; if (cur_code !== 8'd2 || tick !== 1'b0) begin tests_failed++; $display("FAIL sq_mode_change: got %0d/%b want 2/0", cur_code, tick); end
        step(); step(); step();
        step();
        tests_run++; if (cur_code !== 8'd200 || tick !== 1'b1) begin tests_failed++; $display("FAIL sq_high_1: got %0d/%b want 200/1", cur_code, tick); end
        for (int c = 0; c < 4; c++) step();
        tests_run++; if (cur_code !== 8'd0 || tick !== 1'b1) begin tests_failed++; $display("FAIL sq_low_1: got %0d/%b want 0/1", cur_code, tick); end
        step(); step(); step();
        code_in = 8'd50; load = 1'b1;
        step();
        load = 1'b0;
        tests_run++; if (cur_code !== 8'd200) begin tests_failed++; $display("FAIL sq_load_on_tick_old: got %0d want 200", cur_code); end
        for (int c = 0; c < 4; c++) step();
        tests_run++; if (cur_code !== 8'd0) begin tests_failed++; $display("FAIL sq_low_2: got %0d want 0", cur_code); end
        for (int c = 0; c < 4; c++) step();
        tests_run++; if (cur_code !== 8'd50) begin tests_failed++; $display("FAIL sq_high_new: got %0d want 50", cur_code); end
    endtask

    task automatic test_mode_change_on_tick();
        step(); step(); step();
        mode = 2'd0;
        step();
        tests_run++; if (cur_code !== 8'd50) begin tests_failed++; $display("FAIL mchg_tick_code: got %0d want 50", cur_code); end
        tests_run++; if (tick !== 1'b0) begin tests_failed++; $display("FAIL mchg_tick_pulse: got %b want 0", tick); end
        mode = 2'd3;
        step();
        code_in = 8'd77; load = 1'b1;
        step();
        load = 1'b0;
        tests_run++; if (cur_code !== 8'd50) begin tests_failed++; $display("FAIL mode3_pre: got %0d want 50", cur_code); end
        step();
        tests_run++; if (cur_code !== 8'd77) begin tests_failed++; $display("FAIL mode3_static: got %0d want 77", cur_code); end
        // Load with ena low must not reach code_reg.
        ena = 1'b0; code_in = 8'd11; load = 1'b1;
        step();
        load = 1'b0; ena = 1'b1;
        step(); step();
        tests_run++; if (cur_code !== 8'd77) begin tests_failed++; $display("FAIL load_ena_off: got %0d want 77", cur_code); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_static_64();
        test_static_extremes();
        test_triangle();
        test_ena_drop();
        test_reset_mid_ramp();
        test_square();
        test_mode_change_on_tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/opamp_stim_dac.md
Name: opamp_stim_dac

Overview:
- Digital stimulus generator that drives the opamp's non-inverting input (vin_p) through an off-chip RC low-pass filter.
- A first-order sigma-delta modulator converts an 8-bit code into a 1-bit density stream on a digital output pin.
- The code can be static, a triangle sweep, or a square step, so the analog stage can be characterised from a single tile.

Parameters:
- WIDTH, 8, code width in bits; the accumulator is WIDTH+1 bits.
- DIV, 256, clocks per waveform update tick; legal range 2..65536.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- ena  input  1  block enable (the tile's ena).
- code_in  input  WIDTH  target code (mapped from ui_in).
- load  input  1  level-sensitive load strobe for code_in.
- mode  input  2  0 static, 1 triangle, 2 square, 3 reserved (behaves as 0).
- dac_out  output  1  sigma-delta bitstream to the RC filter feeding vin_p.
- cur_code  output  WIDTH  code currently being modulated.
- dir_up  output  1  triangle direction flag; 1 while ramping up.
- tick  output  1  one-cycle pulse on each waveform update.

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous with rst_n low and has priority over ena.
- Reset values: dac_out=0, cur_code=0, dir_up=1, tick=0. Internal registers: code_reg=0, acc=0, prescaler=0, sq_phase=0, mode_q=0.
- Load:
  - Any edge with load=1 and ena=1 sets code_reg<=code_in.
  - Load while ena=0 is ignored.
- Prescaler:
  - Counts 0..DIV-1 while ena=1.
  - tick=1 for exactly the cycle after the prescaler reaches DIV-1, after which the prescaler wraps to 0.
- Mode change:
  - If mode!=mode_q at an edge, the prescaler clears to 0, dir_up<=1 and sq_phase<=0.
  - cur_code is unchanged on that edge.
  - mode_q<=mode.
- Static (mode 0/3): cur_code<=code_reg every cycle, so a load appears on cur_code one cycle after code_reg updates.
- Triangle (mode 1), on each tick:
  - If dir_up: cur_code+1; at 2^WIDTH-1, flip dir_up to 0 and step to 2^WIDTH-2 instead.
  - If down: cur_code-1; at 0, flip dir_up to 1 and step to 1.
  - There is no repeated endpoint value and no wrap-around: sequence ...254,255,254... and ...1,0,1...
  - code_reg is ignored in this mode.
- Square (mode 2), on each tick:
  - sq_phase toggles.
  - cur_code<=code_reg if the new sq_phase=1, else 0.
- Modulator:
  - acc<={1'b0,acc[WIDTH-1:0]}+cur_code each enabled cycle.
  - dac_out<=carry bit acc_next[WIDTH], registered, with one cycle of latency.
  - Ones density over 2^WIDTH cycles equals cur_code exactly while cur_code is stable.
- ena=0:
  - dac_out forced to 0 on the next edge.
  - acc and prescaler cleared.
  - cur_code, dir_up, code_reg and sq_phase held.
  - tick=0.
  - Re-enabling resumes from the held code with acc=0.
- Simultaneous events:
  - load coinciding with a tick in square mode: the tick uses the old code_reg and the new value applies from the next tick.
  - Mode change coinciding with a tick: the mode change wins and no waveform step occurs.
- Reset asserted mid-ramp returns all state to reset values on that edge. The ramp restarts from 0 upward after release.

Test Plan:
- Reset, then ena=1, mode=0, load code_in=64 -> cur_code=64 two edges after load. Over the next 256 cycles dac_out has exactly 64 ones, in a period-4 pattern (one 1 in every 4 cycles).
- Static with code 0 and with code 255 -> dac_out constantly 0, and 255 ones in every 256-cycle window respectively.
- DIV=4, mode=1 from cur_code=0 -> cur_code steps by 1 every 4 cycles and reaches 255. The next tick gives 254 with dir_up=0. Continuing gives 0, then 1 with dir_up=1. tick pulses every 4 cycles.
- DIV=4, mode=2, code_reg=200 -> cur_code alternates 200/0 every 4 cycles. A load of 50 landing on a tick edge takes effect at the following high phase.
- Mid-triangle at cur_code=100: drop ena for 10 cycles -> dac_out=0, no tick, cur_code stays 100. After re-enable the ramp continues 101,102,...
- Assert rst_n=0 for one edge while cur_code=180 ramping down -> on the next edge cur_code=0, dir_up=1, dac_out=0. After release with mode=1 held, the ramp counts up from 0.
